fetch_unit: RTL and testbench

Instruction-fetch stage that consumes the redirect produced by the branch/jump resolution logic (`flow_change`, `next_pc`) and owns the architectural fetch PC. It issues in-order word fetches to instruction memory over a valid/ready request channel, buffers returning instructions with their PCs, and hands them to decode over a valid/ready channel. On a redirect it reloads the PC, flushes the buffer, and discards responses still in flight.

---
 rtl/fetch_unit.sv | 178 +++++++++++++++++
 tb/tb_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the fetch PC, issues in-order word
// fetches over a valid/ready request channel, tags in-flight requests with their
// PCs, buffers returning instructions and hands them to decode. A redirect
// reloads the PC, flushes the buffer and discards responses still in flight.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN -- a misaligned redirect
// target halts fetch and presents a single fault entry (adds port if_fault).
module fetch_unit #(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flow_change,
   input  logic [63:0] next_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [63:0] if_pc
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic        if_fault
`endif
);

   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(BUF_DEPTH);

`ifdef FETCH_MISALIGN_CHECK_EN
   typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_t;
`else
   typedef enum logic {S_RUN, S_FLUSH} state_t;
`endif

   // instruction buffer (circular) and in-flight PC tag queue
   logic [63:0]   r_buf_pc    [BUF_DEPTH];
   logic [31:0]   r_buf_instr [BUF_DEPTH];
`ifdef FETCH_MISALIGN_CHECK_EN
   logic          r_buf_fault [BUF_DEPTH];
`endif
   logic [PW-1:0] r_buf_head;
   logic [PW-1:0] r_buf_tail;
   logic [CW-1:0] r_buf_cnt;
   logic [63:0]   r_tag [BUF_DEPTH];
   logic [PW-1:0] r_tag_head;
   logic [PW-1:0] r_tag_tail;
   logic [CW-1:0] r_live_cnt;
   logic [CW-1:0] r_drop_cnt;
   logic [63:0]   r_fetch_pc;
   state_t        r_state;

   logic          w_halted;
   logic          w_deq;
   logic          w_rsp_drop;
   logic          w_rsp_keep;
   logic          w_rsp_counted;
   logic          w_req_fire;
   logic          w_misaligned;
   logic [CW:0]   w_committed;
   logic [63:0]   w_target;
   logic [CW-1:0] w_drop_next;
   logic [CW-1:0] w_drop_after_redirect;

   // handshake decodes, capacity accounting and redirect target
   always_comb begin
      w_deq         = (r_buf_cnt != '0) && if_ready;
      w_rsp_drop    = imem_rsp_valid && (r_drop_cnt != '0);
      // in RUN nothing is pending discard, so a response belongs to the tag head
      w_rsp_keep    = imem_rsp_valid && (r_state == S_RUN) && (r_live_cnt != '0);
      // a response arriving during a redirect retires one outstanding request
      w_rsp_counted = w_rsp_drop || (imem_rsp_valid && (r_live_cnt != '0));
      // an entry being drained by decode this cycle counts as a free slot,
      // which is what sustains one request per cycle at BUF_DEPTH=2
      w_committed   = (CW+1)'(r_buf_cnt) - (CW+1)'(w_deq)
                    + (CW+1)'(r_live_cnt) + (CW+1)'(r_drop_cnt);
      w_drop_next   = r_drop_cnt - CW'(w_rsp_drop);
      w_drop_after_redirect = r_drop_cnt + r_live_cnt - CW'(w_rsp_counted);
`ifdef FETCH_MISALIGN_CHECK_EN
      w_halted      = (r_state == S_HALT);
      w_target      = next_pc;
      w_misaligned  = (next_pc[1:0] != 2'b00);
`else
      w_halted      = 1'b0;
      w_target      = next_pc & ~64'h3;
      w_misaligned  = 1'b0;
`endif
      imem_req_valid = !rst && !flow_change && !w_halted && (w_committed < DEPTH_W);
      w_req_fire     = imem_req_valid && imem_req_ready;
   end

   // output views of the fetch PC and the buffer head
   always_comb begin
      imem_req_addr = r_fetch_pc;
      if_valid      = (r_buf_cnt != '0);
      if_instr      = r_buf_instr[r_buf_head];
      if_pc         = r_buf_pc[r_buf_head];
`ifdef FETCH_MISALIGN_CHECK_EN
      if_fault      = if_valid && r_buf_fault[r_buf_head];
`endif
   end

   // fetch PC, tag queue, buffer, outstanding counters and RUN/FLUSH/HALT state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
         r_buf_head <= '0;
         r_buf_tail <= '0;
         r_buf_cnt  <= '0;
         r_tag_head <= '0;
         r_tag_tail <= '0;
         r_live_cnt <= '0;
         r_drop_cnt <= '0;
         r_state    <= S_RUN;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            r_buf_pc[i]    <= '0;
            r_buf_instr[i] <= '0;
            r_tag[i]       <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            r_buf_fault[i] <= 1'b0;
`endif
         end
      end else if (flow_change) begin
         // redirect: everything in flight becomes discardable, buffer flushed
         r_fetch_pc <= w_target;
         r_buf_head <= '0;
         r_tag_head <= '0;
         r_tag_tail <= '0;
         r_live_cnt <= '0;
         r_drop_cnt <= w_drop_after_redirect;
`ifdef FETCH_MISALIGN_CHECK_EN
         if (w_misaligned) begin
            r_buf_pc[0]    <= next_pc;
            r_buf_instr[0] <= 32'h0000_0013;
            r_buf_fault[0] <= 1'b1;
            r_buf_tail     <= PW'(1);
            r_buf_cnt      <= CW'(1);
            r_state        <= S_HALT;
         end else
`endif
         begin
            r_buf_tail <= '0;
            r_buf_cnt  <= '0;
            r_state    <= (w_drop_after_redirect != '0) ? S_FLUSH : S_RUN;
         end
      end else begin
         if (w_req_fire) begin
            r_tag[r_tag_tail] <= r_fetch_pc;
            r_tag_tail        <= r_tag_tail + 1'b1;
            r_fetch_pc        <= r_fetch_pc + 64'd4;
         end
         if (w_rsp_keep) begin
            r_buf_pc[r_buf_tail]    <= r_tag[r_tag_head];
            r_buf_instr[r_buf_tail] <= imem_rsp_data;
`ifdef FETCH_MISALIGN_CHECK_EN
            r_buf_fault[r_buf_tail] <= 1'b0;
`endif
            r_buf_tail              <= r_buf_tail + 1'b1;
            r_tag_head              <= r_tag_head + 1'b1;
         end
         if (w_deq) begin
            r_buf_head <= r_buf_head + 1'b1;
         end
         r_buf_cnt  <= r_buf_cnt + CW'(w_rsp_keep) - CW'(w_deq);
         r_live_cnt <= r_live_cnt + CW'(w_req_fire) - CW'(w_rsp_keep);
         r_drop_cnt <= w_drop_next;
`ifdef FETCH_MISALIGN_CHECK_EN
         if (r_state != S_HALT)
`endif
            r_state <= (w_drop_next != '0) ? S_FLUSH : S_RUN;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. A memory model answers the
// DUT's requests after a programmable latency; a high-level model (epoch-tagged
// requests, queue of instructions owed to decode) is compared every cycle, and
// literal expectations pin the key scenarios.
module tb_fetch_unit;
   localparam logic [63:0] RESET_PC  = 64'h0;
   localparam int          BUF_DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        flow_change;
   logic [63:0] next_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [63:0] if_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        if_fault;
`endif

   fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
      .clk(clk), .rst(rst), .flow_change(flow_change), .next_pc(next_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_ready(if_ready),
      .if_instr(if_instr), .if_pc(if_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
      , .if_fault(if_fault)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { logic [63:0] addr; int epoch; int due; } req_t;
   typedef struct { logic [63:0] pc; logic [31:0] instr; logic fault; int cyc; } ent_t;
   typedef struct { logic [63:0] addr; int cyc; } acc_t;

   req_t pipe[$];
   ent_t exp_q[$];
   ent_t hs_log[$];
   acc_t req_log[$];

   int          checks = 0;
   int          passes = 0;
   int          cyc = 0;
   int          epoch = 0;
   int          lat = 1;
   logic        halted = 1'b0;
   logic        rst_prev = 1'b0;
   logic [63:0] model_pc = RESET_PC;

   function automatic logic [31:0] mem_data(input logic [63:0] a);
      return a[31:0] ^ 32'hCAFE_0000;
   endfunction

   function automatic logic [63:0] ra(input int i);
      return (i < req_log.size()) ? req_log[i].addr : 64'hDEAD_DEAD_DEAD_DEAD;
   endfunction
   function automatic int rc(input int i);
      return (i < req_log.size()) ? req_log[i].cyc : -1000;
   endfunction
   function automatic logic [63:0] hpc(input int i);
      return (i < hs_log.size()) ? hs_log[i].pc : 64'hDEAD_DEAD_DEAD_DEAD;
   endfunction
   function automatic logic [31:0] hins(input int i);
      return (i < hs_log.size()) ? hs_log[i].instr : 32'hDEAD_DEAD;
   endfunction
   function automatic int hc(input int i);
      return (i < hs_log.size()) ? hs_log[i].cyc : -1000;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got === want) passes++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // memory model, per-cycle comparison and reference model update
   initial begin : mon
      ent_t        e;
      req_t        r;
      logic        hs;
      logic        exp_req;
      logic        acc;
      logic [63:0] tgt;
      logic        mis;
      forever begin
         @(negedge clk);
         if (!rst && pipe.size() > 0 && pipe[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(pipe[0].addr);
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
         end
         if (rst_prev) begin
            check("rst_if_valid", 64'(if_valid), 64'd0);
            check("rst_if_pc", if_pc, 64'd0);
            check("rst_if_instr", 64'(if_instr), 64'd0);
            check("rst_req_addr", imem_req_addr, RESET_PC);
`ifdef FETCH_MISALIGN_CHECK_EN
            check("rst_if_fault", 64'(if_fault), 64'd0);
`endif
         end
         if (rst) begin
            check("rst_req_valid", 64'(imem_req_valid), 64'd0);
            pipe.delete();
            exp_q.delete();
            halted   = 1'b0;
            model_pc = RESET_PC;
            epoch++;
         end else begin
            hs      = (exp_q.size() > 0) && if_ready;
            exp_req = !flow_change && !halted &&
                      (exp_q.size() - (hs ? 1 : 0) + pipe.size() < BUF_DEPTH);
            check("req_valid", 64'(imem_req_valid), 64'(exp_req));
            if (exp_req) check("req_addr", imem_req_addr, model_pc);
            check("if_valid", 64'(if_valid), 64'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
               check("if_pc", if_pc, exp_q[0].pc);
               check("if_instr", 64'(if_instr), 64'(exp_q[0].instr));
`ifdef FETCH_MISALIGN_CHECK_EN
               check("if_fault", 64'(if_fault), 64'(exp_q[0].fault));
`endif
            end
            acc = imem_req_valid && imem_req_ready;
            if (acc) begin
               $display("[%0d] request addr=%h", cyc, imem_req_addr);
               req_log.push_back('{addr: imem_req_addr, cyc: cyc});
            end
            if (if_valid && if_ready) begin
`ifdef FETCH_MISALIGN_CHECK_EN
               e.fault = if_fault;
`else
               e.fault = 1'b0;
`endif
               e.pc = if_pc; e.instr = if_instr; e.cyc = cyc;
               $display("[%0d] decode pc=%h instr=%h fault=%0d", cyc, if_pc, if_instr, e.fault);
               hs_log.push_back(e);
            end
            // model state after the coming edge
            if (hs) void'(exp_q.pop_front());
            if (imem_rsp_valid) begin
               r = pipe.pop_front();
               if (r.epoch == epoch && !flow_change) begin
                  e.pc = r.addr; e.instr = mem_data(r.addr); e.fault = 1'b0; e.cyc = cyc;
                  exp_q.push_back(e);
               end
            end
            if (acc) begin
               pipe.push_back('{addr: imem_req_addr, epoch: epoch, due: cyc + lat});
               model_pc = model_pc + 64'd4;
            end
            if (flow_change) begin
               exp_q.delete();
               epoch++;
`ifdef FETCH_MISALIGN_CHECK_EN
               tgt = next_pc;
               mis = (next_pc[1:0] != 2'b00);
`else
               tgt = next_pc & ~64'h3;
               mis = 1'b0;
`endif
               model_pc = tgt;
               halted   = mis;
               if (mis) begin
                  e.pc = next_pc; e.instr = 32'h0000_0013; e.fault = 1'b1; e.cyc = cyc;
                  exp_q.push_back(e);
               end
            end
         end
         rst_prev = rst;
         cyc++;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "bench timeout");
   end

   // directed scenarios
   initial begin : stim
      int rb;
      int hb;
      int rbw;
      rst = 1'b1; flow_change = 1'b0; next_pc = '0;
      imem_req_ready = 1'b1; if_ready = 1'b1; lat = 1;
      repeat (3) tick();

      // reset release, 1-cycle memory, decode always ready
      rst = 1'b0;
      rb = req_log.size(); hb = hs_log.size();
      repeat (8) tick();
      check("s1_req0", ra(rb), 64'h0);
      check("s1_req1", ra(rb+1), 64'h4);
      check("s1_req2", ra(rb+2), 64'h8);
      check("s1_req_gap", 64'(rc(rb+2) - rc(rb)), 64'd2);
      check("s1_pc0", hpc(hb), 64'h0);
      check("s1_pc1", hpc(hb+1), 64'h4);
      check("s1_pc2", hpc(hb+2), 64'h8);
      check("s1_instr1", 64'(hins(hb+1)), 64'hCAFE_0004);
      check("s1_hs_gap", 64'(hc(hb+2) - hc(hb)), 64'd2);
      check("s1_first_lat", 64'(hc(hb) - rc(rb)), 64'd2);

      // reset mid-operation with requests outstanding, then decode stalled
      lat = 3;
      repeat (3) tick();
      rst = 1'b1; if_ready = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      rb = req_log.size(); hb = hs_log.size();
      repeat (6) tick();
      check("s2_req_count", 64'(req_log.size() - rb), 64'd2);
      check("s2_req0", ra(rb), RESET_PC);
      check("s2_req1", ra(rb+1), 64'h4);
      check("s2_no_hs", 64'(hs_log.size() - hb), 64'd0);
      if_ready = 1'b1;
      repeat (8) tick();
      check("s2_resume", ra(rb+2), 64'h8);
      check("s2_pc0", hpc(hb), 64'h0);
      check("s2_pc1", hpc(hb+1), 64'h4);
      check("s2_pc2", hpc(hb+2), 64'h8);

      // latency 3, redirect with two requests in flight
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (2) tick();
      flow_change = 1'b1; next_pc = 64'h100;
      hb = hs_log.size(); rb = req_log.size();
      tick();
      flow_change = 1'b0;
      repeat (12) tick();
      check("s3_req0", ra(rb), 64'h100);
      check("s3_pc0", hpc(hb), 64'h100);
      check("s3_pc1", hpc(hb+1), 64'h104);
      check("s3_pc2", hpc(hb+2), 64'h108);

      // redirect coinciding with a response and a decode handshake
      rst = 1'b1; lat = 1;
      tick();
      rst = 1'b0;
      repeat (5) tick();
      flow_change = 1'b1; next_pc = 64'h300;
      hb = hs_log.size(); rb = req_log.size();
      tick();
      flow_change = 1'b0;
      repeat (5) tick();
      check("s4_hs_at_redirect", hpc(hb), 64'hC);
      check("s4_next_pc", hpc(hb+1), 64'h300);
      check("s4_req0", ra(rb), 64'h300);
      check("s4_req_lat", 64'(rc(rb) - hc(hb)), 64'd1);

      // redirect to a misaligned target
      flow_change = 1'b1; next_pc = 64'h102;
      rb = req_log.size();
      tick();
      flow_change = 1'b0;
      hb = hs_log.size();
`ifdef FETCH_MISALIGN_CHECK_EN
      repeat (6) tick();
      check("s5_no_req", 64'(req_log.size() - rb), 64'd0);
      check("s5_one_hs", 64'(hs_log.size() - hb), 64'd1);
      check("s5_fault_pc", hpc(hb), 64'h102);
      check("s5_fault_instr", 64'(hins(hb)), 64'h13);
      check("s5_fault_flag", 64'((hb < hs_log.size()) ? hs_log[hb].fault : 1'b0), 64'd1);
      flow_change = 1'b1; next_pc = 64'h200;
      rb = req_log.size();
      tick();
      flow_change = 1'b0;
      repeat (4) tick();
      check("s5_after_halt", ra(rb), 64'h200);
`else
      repeat (5) tick();
      check("s5_req0", ra(rb), 64'h100);
      check("s5_pc0", hpc(hb), 64'h100);
`endif

      // mixed backpressure, latency 2, redirect near the top of the address space
      lat = 2;
      rbw = 0;
      for (int i = 0; i < 60; i++) begin
         imem_req_ready = ((i % 3) != 1);
         if_ready       = ((i % 5) != 2);
         flow_change    = (i == 20) || (i == 41);
         next_pc        = (i == 20) ? 64'h1000 : 64'hFFFF_FFFF_FFFF_FFF8;
         if (i == 41) rbw = req_log.size();
         tick();
      end
      flow_change = 1'b0; imem_req_ready = 1'b1; if_ready = 1'b1;
      repeat (6) tick();
      check("s7_wrap0", ra(rbw), 64'hFFFF_FFFF_FFFF_FFF8);
      check("s7_wrap1", ra(rbw+1), 64'hFFFF_FFFF_FFFF_FFFC);
      check("s7_wrap2", ra(rbw+2), 64'h0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
